// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, memory-arbiter state encoding and requester IDs.
// Consumed by mem_arbiter and arb2; the round-robin option is selected with ARB_RR_EN.
package cpu_pkg;

    localparam int CPU_AW = 8;
    localparam int CPU_DW = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // Requester IDs double as bit positions in the one-hot winner vector.
    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_LOAD  = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb2.sv
// Two-input winner select producing a one-hot grant vector indexed by requester ID.
// ARB_RR_EN: contended requests alternate using the last-winner pointer; otherwise the loader wins.
module arb2
    import cpu_pkg::*;
(
    input  logic       i_req_f,
    input  logic       i_req_l,
`ifdef ARB_RR_EN
    input  logic       i_last,
`endif
    output logic [1:0] o_win
);

    always_comb begin
        // NOTE: default assignment first, so every path drives o_win and no latch is inferred.
        o_win = 2'b00;
        if (i_req_f && i_req_l) begin
`ifdef ARB_RR_EN
            o_win[(i_last == REQ_LOAD) ? REQ_FETCH : REQ_LOAD] = 1'b1;
`else
            o_win[REQ_LOAD] = 1'b1;
`endif
        end else if (i_req_f) begin
            o_win[REQ_FETCH] = 1'b1;
        end else if (i_req_l) begin
            o_win[REQ_LOAD] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous single-port RAM between instruction fetch and a loader/debug port.
// One access every three cycles (IDLE -> ACCESS -> RESP); ARB_RR_EN enables round-robin contention.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int AW = CPU_AW,
    parameter int DW = CPU_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_valid,
    output logic [DW-1:0] f_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_gnt,
    output logic          l_valid,
    output logic [DW-1:0] l_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    arb_state_t r_state;
    logic       r_win_load;
    logic       r_write;
    logic [1:0] w_win;
    logic       w_any;

`ifdef ARB_RR_EN
    logic       r_last;

    arb2 u_arb2 (
        .i_req_f (f_req),
        .i_req_l (l_req),
        .i_last  (r_last),
        .o_win   (w_win)
    );
`else
    arb2 u_arb2 (
        .i_req_f (f_req),
        .i_req_l (l_req),
        .o_win   (w_win)
    );
`endif

    assign w_any = |w_win;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_win_load <= 1'b0;
            r_write    <= 1'b0;
            f_gnt      <= 1'b0;
            f_valid    <= 1'b0;
            f_rdata    <= '0;
            l_gnt      <= 1'b0;
            l_valid    <= 1'b0;
            l_rdata    <= '0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
`ifdef ARB_RR_EN
            r_last     <= REQ_LOAD;
`endif
        end else begin
            // NOTE: non-blocking everywhere so each register sees pre-edge values of its peers.
            f_gnt   <= 1'b0;
            l_gnt   <= 1'b0;
            f_valid <= 1'b0;
            l_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state    <= ACCESS;
                        r_win_load <= w_win[REQ_LOAD];
                        f_gnt      <= w_win[REQ_FETCH];
                        l_gnt      <= w_win[REQ_LOAD];
                        ram_en     <= 1'b1;
                        if (w_win[REQ_LOAD]) begin
                            ram_addr  <= l_addr;
                            ram_we    <= l_we;
                            ram_wdata <= l_wdata;
                            r_write   <= l_we;
                        end else begin
                            ram_addr  <= f_addr;
                            ram_we    <= 1'b0;
                            ram_wdata <= '0;
                            r_write   <= 1'b0;
                        end
`ifdef ARB_RR_EN
                        r_last <= w_win[REQ_LOAD] ? REQ_LOAD : REQ_FETCH;
`endif
                    end
                end
                ACCESS: begin
                    r_state <= RESP;
                    ram_en  <= 1'b0;
                    ram_we  <= 1'b0;
                end
                RESP: begin
                    // ram_rdata is valid now, one cycle after the enable.
                    r_state <= IDLE;
                    if (r_win_load) begin
                        l_valid <= 1'b1;
                        if (!r_write) begin
                            l_rdata <= ram_rdata;
                        end
                    end else begin
                        f_valid <= 1'b1;
                        f_rdata <= ram_rdata;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, 8, RAM address width.
REQ-002 Parameter DW, 16, RAM data and instruction width.
REQ-003 clk  in  1  system clock, all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 f_req  in  1  instruction-fetch request, read-only.
REQ-006 f_addr  in  AW  fetch address (PC).
REQ-007 f_gnt  out  1  fetch grant, one-cycle pulse.
REQ-008 f_valid  out  1  fetch data valid, one-cycle pulse.
REQ-009 f_rdata  out  DW  fetched instruction.
REQ-010 l_req  in  1  loader/debug request.
REQ-011 l_we  in  1  loader write (1) / read (0).
REQ-012 l_addr  in  AW  loader address.
REQ-013 l_wdata  in  DW  loader write data.
REQ-014 l_gnt  out  1  loader grant, one-cycle pulse.
REQ-015 l_valid  out  1  loader completion pulse (read data valid or write ack).
REQ-016 l_rdata  out  DW  loader read data.
REQ-017 ram_en, ram_we  out  1 each  synchronous single-port RAM enable and write enable.
REQ-018 ram_addr  out  AW; ram_wdata  out  DW; ram_rdata  in  DW (valid the cycle after ram_en).

Function
REQ-019 The FSM SHALL have states IDLE, ACCESS and RESP; IDLE->ACCESS when any req is high, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-020 On the IDLE->ACCESS edge, the block SHALL register the winner's address, we (0 for fetch) and wdata onto the RAM ports and pulse the winner's gnt for exactly the ACCESS cycle.
REQ-021 ram_en SHALL be high only during ACCESS; ram_we = l_we and high only if the loader won.
REQ-022 On the RESP->IDLE edge, the winner's rdata SHALL capture ram_rdata (reads only) and its valid SHALL be high for one cycle; a loader write leaves l_rdata unchanged.
REQ-023 Latency: req seen in IDLE at cycle N -> gnt at N+1 -> valid at N+3; the next grant is no earlier than N+4 (one access per 3 cycles max).
REQ-024 Requesters SHALL hold req and address/data stable until gnt and deassert req the cycle after gnt; the block SHALL sample req only in IDLE.
REQ-025 A req withdrawn before gnt SHALL be ignored without side effects.
REQ-026 A non-winning request SHALL stay pending and be served in the next IDLE cycle.
REQ-027 Without ARB_RR_EN, simultaneous requests SHALL grant the loader (fixed priority).

Reset
REQ-028 rst low SHALL force IDLE and zero all outputs: gnts, valids, rdatas, ram_en, ram_we, ram_addr and ram_wdata.
REQ-029 Reset mid-ACCESS or mid-RESP SHALL abort the access with no valid pulse; the round-robin pointer SHALL reset to "loader last" so fetch wins first.

Configuration
REQ-030 With ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin via a 1-bit last-winner pointer, updated on every grant; without it, fixed priority per REQ-027 applies and no pointer exists.

Structure
REQ-031 Shared package cpu_pkg SHALL hold AW/DW defaults, the arbiter state enum and requester ID constants (REQ_FETCH=0, REQ_LOAD=1).
REQ-032 The winner selection SHALL be a sub-module arb2 (two requests, optional pointer, one-hot winner) instantiated once.

Verification
REQ-033 Single fetch: f_req=1, f_addr=0x05, RAM[5]=0x2345 -> f_gnt at N+1, ram_en with ram_addr 0x05 at N+1, f_valid and f_rdata=0x2345 at N+3.
REQ-034 Loader write then fetch read: l_we=1, l_addr=0x10, l_wdata=0xBEEF, then fetch 0x10 -> l_valid pulse with l_rdata unchanged, then f_rdata=0xBEEF.
REQ-035 Simultaneous f_req and l_req, fixed priority -> l_gnt first and f_gnt 3 cycles later; with ARB_RR_EN over 4 back-to-back contended rounds -> grants alternate F, L, F, L.
REQ-036 Reset asserted during ACCESS -> no valid pulse, all outputs 0; after release, a pending f_req is granted as in REQ-033.
REQ-037 f_req pulses one cycle while the FSM is in RESP (withdrawn before IDLE) -> no f_gnt and no RAM access.
